// File: rtl/debug_sched_pkg.sv
// Shared types and helpers for the debug-mux fault-localisation scheduler.
package debug_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } sched_state_t;

  // Value of the trial pointer's base flag while the no-override trial is current.
  localparam logic TRIAL_BASE = 1'b1;

  localparam int unsigned MAX_GATES = 64;

  function automatic logic [MAX_GATES-1:0] onehot_sel(input int unsigned g);
    logic [MAX_GATES-1:0] sel;
    sel = '0;
    if (g < MAX_GATES) sel[g[5:0]] = 1'b1;
    return sel;
  endfunction

endpackage

// File: rtl/debug_mux_scheduler_trial_pointer.sv
// Gate/pattern nested counter walking BASE, then every (gate, pattern) pair, pattern-minor.
module trial_pointer
  import debug_sched_pkg::*;
#(
  parameter int NUM_GATES = 9,
  parameter int WIDTH     = 3,
  parameter int GW        = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             step,
  output logic [GW-1:0]    gate,
  output logic [WIDTH-1:0] pat,
  output logic             is_base,
  output logic             last,
  output logic [GW-1:0]    next_gate,
  output logic [WIDTH-1:0] next_pat,
  output logic             next_base
);

  logic [GW-1:0]    gate_q, gate_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic             base_q, base_d;

  always_comb begin
    gate_d = gate_q;
    pat_d  = pat_q;
    base_d = base_q;
    if (clear) begin
      gate_d = '0;
      pat_d  = '0;
      base_d = TRIAL_BASE;
    end else if (step) begin
      if (base_q == TRIAL_BASE) begin
        gate_d = '0;
        pat_d  = '0;
        base_d = ~TRIAL_BASE;
      end else begin
        pat_d = pat_q + WIDTH'(1);
        if (pat_q == '1) gate_d = gate_q + GW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_q <= '0;
      pat_q  <= '0;
      base_q <= TRIAL_BASE;
    end else begin
      gate_q <= gate_d;
      pat_q  <= pat_d;
      base_q <= base_d;
    end
  end

  assign gate      = gate_q;
  assign pat       = pat_q;
  assign is_base   = (base_q == TRIAL_BASE);
  assign last      = (base_q != TRIAL_BASE) && (gate_q == GW'(NUM_GATES - 1)) && (pat_q == '1);
  assign next_gate = gate_d;
  assign next_pat  = pat_d;
  assign next_base = (base_d == TRIAL_BASE);

endmodule

// File: rtl/debug_mux_scheduler.sv
// Scans every gate/override pair through the debug muxes and records which ones
// make the netlist outputs match the golden vector.
module debug_mux_scheduler
  import debug_sched_pkg::*;
#(
  parameter int NUM_GATES = 9,
  parameter int WIDTH     = 3,
  parameter int OUT_W     = 9,
  parameter int SETTLE    = 1,
  localparam int GW       = (NUM_GATES > 1) ? $clog2(NUM_GATES) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [OUT_W-1:0]     golden,
  input  logic [OUT_W-1:0]     dut_out,
  output logic [NUM_GATES-1:0] mux_sel,
  output logic [WIDTH-1:0]     mux_data,
  output logic                 busy,
  output logic                 done,
  output logic                 no_fault,
  output logic [NUM_GATES-1:0] candidates,
  output logic [GW-1:0]        first_gate,
  output logic [WIDTH-1:0]     first_pat,
  output logic                 found
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  sched_state_t state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NUM_GATES-1:0] mux_sel_q, mux_sel_d;
  logic [WIDTH-1:0]     mux_data_q, mux_data_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 no_fault_q, no_fault_d;
  logic [NUM_GATES-1:0] candidates_q, candidates_d;
  logic [GW-1:0]        first_gate_q, first_gate_d;
  logic [WIDTH-1:0]     first_pat_q, first_pat_d;
  logic                 found_q, found_d;

  logic                 ptr_clear, ptr_step;
  logic [GW-1:0]        ptr_gate, ptr_next_gate;
  logic [WIDTH-1:0]     ptr_pat, ptr_next_pat;
  logic                 ptr_base, ptr_last, ptr_next_base;
  logic                 match;

  trial_pointer #(
    .NUM_GATES (NUM_GATES),
    .WIDTH     (WIDTH),
    .GW        (GW)
  ) u_ptr (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (ptr_clear),
    .step      (ptr_step),
    .gate      (ptr_gate),
    .pat       (ptr_pat),
    .is_base   (ptr_base),
    .last      (ptr_last),
    .next_gate (ptr_next_gate),
    .next_pat  (ptr_next_pat),
    .next_base (ptr_next_base)
  );

  assign match = (dut_out == golden);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ptr_clear    = 1'b0;
    ptr_step     = 1'b0;
    mux_sel_d    = mux_sel_q;
    mux_data_d   = mux_data_q;
    no_fault_d   = no_fault_q;
    candidates_d = candidates_q;
    first_gate_d = first_gate_q;
    first_pat_d  = first_pat_q;
    found_d      = found_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_APPLY;
          ptr_clear    = 1'b1;
          no_fault_d   = 1'b0;
          candidates_d = '0;
          first_gate_d = '0;
          first_pat_d  = '0;
          found_d      = 1'b0;
        end
      end
      S_APPLY: begin
        cnt_d   = CW'(SETTLE - 1);
        state_d = abort ? S_DONE : S_SETTLE;
      end
      S_SETTLE: begin
        if (abort)              state_d = S_DONE;
        else if (cnt_q == '0)   state_d = S_CHECK;
        else                    cnt_d   = cnt_q - CW'(1);
      end
      S_CHECK: begin
        if (abort) begin
          state_d = S_DONE;
        end else if (ptr_base) begin
          if (match) begin
            no_fault_d = 1'b1;
            state_d    = S_DONE;
          end else begin
            ptr_step = 1'b1;
            state_d  = S_APPLY;
          end
        end else begin
          if (match) begin
            candidates_d[ptr_gate] = 1'b1;
            if (!found_q) begin
              found_d      = 1'b1;
              first_gate_d = ptr_gate;
              first_pat_d  = ptr_pat;
            end
          end
          if (ptr_last) begin
            state_d = S_DONE;
          end else begin
            ptr_step = 1'b1;
            state_d  = S_APPLY;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Mux pins load from the pointer's upcoming value so the override is already
    // on the netlist during the APPLY cycle itself.
    if (state_d == S_APPLY && state_q != S_APPLY) begin
      mux_sel_d  = ptr_next_base ? '0 : NUM_GATES'(onehot_sel(32'(ptr_next_gate)));
      mux_data_d = ptr_next_base ? '0 : ptr_next_pat;
    end else if (state_d == S_DONE || state_d == S_IDLE) begin
      mux_sel_d  = '0;
      mux_data_d = '0;
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      mux_sel_q    <= '0;
      mux_data_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      no_fault_q   <= 1'b0;
      candidates_q <= '0;
      first_gate_q <= '0;
      first_pat_q  <= '0;
      found_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mux_sel_q    <= mux_sel_d;
      mux_data_q   <= mux_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      no_fault_q   <= no_fault_d;
      candidates_q <= candidates_d;
      first_gate_q <= first_gate_d;
      first_pat_q  <= first_pat_d;
      found_q      <= found_d;
    end
  end

  assign mux_sel    = mux_sel_q;
  assign mux_data   = mux_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign no_fault   = no_fault_q;
  assign candidates = candidates_q;
  assign first_gate = first_gate_q;
  assign first_pat  = first_pat_q;
  assign found      = found_q;

endmodule

// File: tb/tb_debug_mux_scheduler.sv
// Testbench for debug_mux_scheduler: a behavioural stand-in netlist plus an
// exhaustive trial-enumeration reference model.
module tb_debug_mux_scheduler;

  localparam int NUM_GATES    = 9;
  localparam int WIDTH        = 3;
  localparam int OUT_W        = 9;
  localparam int SETTLE       = 1;
  localparam int NUM_PATS     = 1 << WIDTH;
  localparam int TRIAL_CYCLES = SETTLE + 2;
  localparam int FULL_DONE    = (1 + NUM_GATES * NUM_PATS) * TRIAL_CYCLES + 1;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic                 abort;
  logic [OUT_W-1:0]     golden;
  logic [OUT_W-1:0]     dut_out;
  logic [NUM_GATES-1:0] mux_sel;
  logic [WIDTH-1:0]     mux_data;
  logic                 busy;
  logic                 done;
  logic                 no_fault;
  logic [NUM_GATES-1:0] candidates;
  logic [3:0]           first_gate;
  logic [WIDTH-1:0]     first_pat;
  logic                 found;

  logic [WIDTH-1:0] nominal [NUM_GATES];
  logic [WIDTH-1:0] fault   [NUM_GATES];

  int assertCount = 0;
  int failCount   = 0;

  logic             expNoFault, expFound;
  logic [NUM_GATES-1:0] expCand;
  int               expFirstGate, expFirstPat, expDone;

  always #5 clk = ~clk;

  debug_mux_scheduler #(
    .NUM_GATES (NUM_GATES),
    .WIDTH     (WIDTH),
    .OUT_W     (OUT_W),
    .SETTLE    (SETTLE)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .golden     (golden),
    .dut_out    (dut_out),
    .mux_sel    (mux_sel),
    .mux_data   (mux_data),
    .busy       (busy),
    .done       (done),
    .no_fault   (no_fault),
    .candidates (candidates),
    .first_gate (first_gate),
    .first_pat  (first_pat),
    .found      (found)
  );

  // Stand-in netlist: each gate yields a 3-bit value (nominal, possibly faulted,
  // or the mux override); gates i, i+3, i+6 XOR together into output slice i%3.
  always_comb begin
    logic [OUT_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < NUM_GATES; i++)
      acc[3*(i%3) +: 3] = acc[3*(i%3) +: 3] ^ (mux_sel[i] ? mux_data : (nominal[i] ^ fault[i]));
    dut_out = acc;
  end

  function automatic logic [OUT_W-1:0] netOut(input int g, input logic [WIDTH-1:0] p);
    logic [OUT_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < NUM_GATES; i++)
      acc[3*(i%3) +: 3] = acc[3*(i%3) +: 3] ^ ((i == g) ? p : (nominal[i] ^ fault[i]));
    return acc;
  endfunction

  // Reference: enumerate trials in scan order, keeping only those whose
  // compare completes before an abort.
  task automatic buildExpectation(input int abortAt);
    int checkCycle;
    expNoFault = 1'b0; expFound = 1'b0; expCand = '0;
    expFirstGate = 0; expFirstPat = 0;
    if (netOut(-1, '0) === golden) begin
      expNoFault = 1'b1;
      expDone    = TRIAL_CYCLES + 1;
      return;
    end
    expDone = FULL_DONE;
    for (int k = 0; k < NUM_GATES * NUM_PATS; k++) begin
      checkCycle = (k + 2) * TRIAL_CYCLES;
      if (abortAt > 0 && checkCycle >= abortAt) break;
      if (netOut(k / NUM_PATS, WIDTH'(k % NUM_PATS)) === golden) begin
        expCand[k / NUM_PATS] = 1'b1;
        if (!expFound) begin
          expFound = 1'b1;
          expFirstGate = k / NUM_PATS;
          expFirstPat  = k % NUM_PATS;
        end
      end
    end
    if (abortAt > 0 && abortAt + 1 < expDone) expDone = abortAt + 1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, ".mux_sel"},    32'(mux_sel),    0);
    checkOutput({tag, ".mux_data"},   32'(mux_data),   0);
    checkOutput({tag, ".busy"},       32'(busy),       0);
    checkOutput({tag, ".done"},       32'(done),       0);
    checkOutput({tag, ".no_fault"},   32'(no_fault),   0);
    checkOutput({tag, ".found"},      32'(found),      0);
    checkOutput({tag, ".candidates"}, 32'(candidates), 0);
    checkOutput({tag, ".first_gate"}, 32'(first_gate), 0);
    checkOutput({tag, ".first_pat"},  32'(first_pat),  0);
  endtask

  task automatic checkResults(input string tag);
    checkOutput({tag, ".no_fault"},   32'(no_fault),   32'(expNoFault));
    checkOutput({tag, ".found"},      32'(found),      32'(expFound));
    checkOutput({tag, ".candidates"}, 32'(candidates), 32'(expCand));
    checkOutput({tag, ".first_gate"}, 32'(first_gate), 32'(expFirstGate));
    checkOutput({tag, ".first_pat"},  32'(first_pat),  32'(expFirstPat));
  endtask

  // Runs one scan from start, tracking the expected override per cycle and
  // the done cycle; abortAt/startPulseAt are scan-cycle numbers (0 = never).
  task automatic applyStimulus(input logic abortWithStart, input int abortAt,
                               input int startPulseAt, input string tag);
    int n, doneAt, t, k;
    logic [NUM_GATES-1:0] expSel;
    logic [WIDTH-1:0]     expDat;
    @(negedge clk);
    start = 1'b1; abort = abortWithStart;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    n = 1; doneAt = -1;
    while (n <= FULL_DONE + 20) begin
      if (done === 1'b1) begin
        doneAt = n;
        break;
      end
      if (n < expDone) begin
        t = (n - 1) / TRIAL_CYCLES;
        expSel = '0; expDat = '0;
        if (t > 0) begin
          k = t - 1;
          expSel[k / NUM_PATS] = 1'b1;
          expDat = WIDTH'(k % NUM_PATS);
        end
        checkOutput($sformatf("%s.sel@%0d", tag, n),  32'(mux_sel),  32'(expSel));
        checkOutput($sformatf("%s.data@%0d", tag, n), 32'(mux_data), 32'(expDat));
        checkOutput($sformatf("%s.busy@%0d", tag, n), 32'(busy),     1);
      end
      abort = (n == abortAt);
      start = (n == startPulseAt);
      @(negedge clk);
      n++;
    end
    start = 1'b0; abort = 1'b0;
    checkOutput({tag, ".doneCycle"},  32'(doneAt),  32'(expDone));
    checkOutput({tag, ".doneSel"},    32'(mux_sel), 0);
    checkOutput({tag, ".doneBusy"},   32'(busy),    1);
    checkResults({tag, ".atDone"});
    @(negedge clk);
    checkOutput({tag, ".doneFall"}, 32'(done), 0);
    checkOutput({tag, ".busyFall"}, 32'(busy), 0);
    checkResults({tag, ".held"});
  endtask

  task automatic randomNominal();
    for (int i = 0; i < NUM_GATES; i++) begin
      nominal[i] = WIDTH'($urandom_range(0, NUM_PATS - 1));
      fault[i]   = '0;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; golden = '0;
    for (int i = 0; i < NUM_GATES; i++) begin
      nominal[i] = '0;
      fault[i]   = '0;
    end
    #12;
    checkResetOutputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] unfaulted netlist");
    randomNominal();
    golden = netOut(-1, '0);
    buildExpectation(0);
    applyStimulus(1'b0, 0, 0, "noFault");
    checkOutput("noFault.flag", 32'(no_fault), 1);

    $display("[TB] gate u2 bit 1 inverted, start pulsed while busy");
    randomNominal();
    nominal[2] = 3'b101;
    golden = netOut(-1, '0);
    fault[2] = 3'b010;
    buildExpectation(0);
    applyStimulus(1'b0, 0, 50, "gateU2");
    checkOutput("gateU2.cand2", 32'(candidates[2]), 1);
    checkOutput("gateU2.gate",  32'(first_gate),    2);
    checkOutput("gateU2.pat",   32'(first_pat),     5);

    $display("[TB] unreachable golden, abort alongside start");
    randomNominal();
    golden = netOut(-1, '0) ^ 9'b000_010_001;
    buildExpectation(0);
    applyStimulus(1'b1, 0, 0, "unreachable");

    $display("[TB] abort in scan cycle 10");
    randomNominal();
    nominal[0] = 3'b001;
    golden = netOut(-1, '0);
    fault[0] = 3'b100;
    buildExpectation(10);
    applyStimulus(1'b0, 10, 0, "abort");
    checkOutput("abort.first", 32'(first_pat), 1);

    $display("[TB] reset during SETTLE");
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("preReset.sel", 32'(mux_sel), 1);
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midReset");
    @(negedge clk);
    rst_n = 1'b1;
    randomNominal();
    nominal[2] = 3'b101;
    golden = netOut(-1, '0);
    fault[2] = 3'b010;
    buildExpectation(0);
    applyStimulus(1'b0, 0, 0, "afterReset");

    $display("[TB] random faults");
    for (int r = 0; r < 3; r++) begin
      randomNominal();
      golden = netOut(-1, '0);
      fault[$urandom_range(0, NUM_GATES - 1)] = WIDTH'($urandom_range(0, NUM_PATS - 1));
      buildExpectation(0);
      applyStimulus(1'b0, 0, 0, $sformatf("random%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
